lcd_value_display: RTL and testbench

LCD_VALUE_DISPLAY -- requirements
Module: lcd_value_display

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_value_display_if.sv | 12 +
 rtl/lcd_write.sv | 82 ++++++++
 rtl/lcd_value_display.sv | 133 +++++++++++++
 tb/tb_lcd_value_display.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 value display: FSM encodings, command bytes and ASCII offsets.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_ADDR, S_DIG2, S_DIG1, S_DIG0
    } state_t;

    typedef enum logic [2:0] {
        W_IDLE, W_SETUP, W_STROBE, W_HOLD, W_WAIT
    } wr_state_t;

    localparam logic [7:0] CMD_WAKE    = 8'h30;
    localparam logic [7:0] CMD_FUNC    = 8'h38;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_HOME_L1 = 8'h80;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int unsigned N_INIT = 7;

    // Power-on command list: three wake-ups, 8-bit/2-line, display on, clear, entry mode.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_cmd = CMD_WAKE;
            3'd3:             init_cmd = CMD_FUNC;
            3'd4:             init_cmd = CMD_DISP_ON;
            3'd5:             init_cmd = CMD_CLEAR;
            default:          init_cmd = CMD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_value_display_if.sv
// Value input and HD44780 bus of the value display; master drives value, slave drives the LCD pins.
interface lcd_value_display_if;
    logic [7:0] value;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;
    logic       busy;

    modport master (output value, input lcd_rs, lcd_rw, lcd_e, lcd_db, busy);
    modport slave  (input value, output lcd_rs, lcd_rw, lcd_e, lcd_db, busy);
endinterface

// File: rtl/lcd_write.sv
// One HD44780 byte write: setup cycle, enable strobe, hold cycle, then the post-write wait.
module lcd_write
    import lcd_pkg::*;
#(
    parameter int unsigned T_EPW = 25,
    parameter int unsigned T_CMD = 2000,
    parameter int unsigned T_CLR = 82000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       clr_wait,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);
    localparam int unsigned CW = $clog2(T_CLR + 1);

    wr_state_t       r_st;
    logic [CW-1:0]   r_cnt;
    logic            r_clr;
    logic            r_done;
    logic            r_e;
    logic            r_rs;
    logic [7:0]      r_db;
    logic [CW-1:0]   w_lim;

    assign w_lim  = r_clr ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
    assign done   = r_done;
    assign lcd_rs = r_rs;
    assign lcd_e  = r_e;
    assign lcd_db = r_db;

    // rs/db are only reloaded on the next start, so they stay put through hold and wait
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_st   <= W_IDLE;
            r_cnt  <= '0;
            r_clr  <= 1'b0;
            r_done <= 1'b0;
            r_e    <= 1'b0;
            r_rs   <= 1'b0;
            r_db   <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_st)
                W_IDLE: if (start) begin
                    r_rs  <= rs;
                    r_db  <= data;
                    r_clr <= clr_wait;
                    r_st  <= W_SETUP;
                end
                W_SETUP: begin
                    r_e   <= 1'b1;
                    r_cnt <= '0;
                    r_st  <= W_STROBE;
                end
                W_STROBE: if (r_cnt == CW'(T_EPW - 1)) begin
                    r_e  <= 1'b0;
                    r_st <= W_HOLD;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                W_HOLD: begin
                    r_cnt <= '0;
                    r_st  <= W_WAIT;
                end
                W_WAIT: if (r_cnt == w_lim) begin
                    r_done <= 1'b1;
                    r_st   <= W_IDLE;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: r_st <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_value_display.sv
// Shows an 8-bit unsigned value as three blanked decimal digits on an HD44780 in 8-bit mode.
module lcd_value_display
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_EPW   = 25,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic               clk_in,
    input  logic               rst_n,
    lcd_value_display_if.slave bus
);
    localparam int unsigned PW = $clog2(T_PWRUP + 1);

    state_t          r_state;
    logic [PW-1:0]   r_tmr;
    logic [2:0]      r_idx;
    logic [7:0]      r_shown;
    logic            r_force;
    logic            r_start;
    logic            r_issued;
    logic            r_busy;

    logic [3:0]      w_hund;
    logic [3:0]      w_tens;
    logic [3:0]      w_ones;
    logic [7:0]      w_data;
    logic            w_rs;
    logic            w_clr;
    logic            w_done;

    assign w_hund = 4'(r_shown / 8'd100);
    assign w_tens = 4'((r_shown / 8'd10) % 8'd10);
    assign w_ones = 4'(r_shown % 8'd10);

    // Byte for the current state; leading zeros become spaces, the ones digit never does
    always_comb begin
        w_data = ASCII_SPACE;
        w_rs   = 1'b1;
        case (r_state)
            S_INIT: begin
                w_rs   = 1'b0;
                w_data = init_cmd(r_idx);
            end
            S_ADDR: begin
                w_rs   = 1'b0;
                w_data = CMD_HOME_L1;
            end
            S_DIG2: if (w_hund != 4'd0) w_data = ASCII_ZERO + 8'(w_hund);
            S_DIG1: if (w_hund != 4'd0 || w_tens != 4'd0) w_data = ASCII_ZERO + 8'(w_tens);
            S_DIG0: w_data = ASCII_ZERO + 8'(w_ones);
            default: ;
        endcase
    end

    assign w_clr = !w_rs && (w_data == CMD_CLEAR);

    lcd_write #(
        .T_EPW (T_EPW),
        .T_CMD (T_CMD),
        .T_CLR (T_CLR)
    ) u_write (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .start    (r_start),
        .rs       (w_rs),
        .data     (w_data),
        .clr_wait (w_clr),
        .done     (w_done),
        .lcd_rs   (bus.lcd_rs),
        .lcd_e    (bus.lcd_e),
        .lcd_db   (bus.lcd_db)
    );

    assign bus.lcd_rw = 1'b0;
    assign bus.busy   = r_busy;

    // Byte sequencer: each write state issues one start and advances on the writer's done
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_PWRUP;
            r_tmr    <= '0;
            r_idx    <= 3'd0;
            r_shown  <= 8'h00;
            r_force  <= 1'b0;
            r_start  <= 1'b0;
            r_issued <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_PWRUP: if (r_tmr == PW'(T_PWRUP - 1)) begin
                    r_tmr   <= '0;
                    r_idx   <= 3'd0;
                    r_state <= S_INIT;
                end else begin
                    r_tmr <= r_tmr + PW'(1);
                end
                S_IDLE: if (bus.value != r_shown || r_force) begin
                    r_shown <= bus.value;
                    r_force <= 1'b0;
                    r_state <= S_ADDR;
                    r_busy  <= 1'b1;
                end
                default: if (!r_issued) begin
                    r_start  <= 1'b1;
                    r_issued <= 1'b1;
                end else if (w_done) begin
                    r_issued <= 1'b0;
                    case (r_state)
                        S_INIT: if (r_idx == 3'(N_INIT - 1)) begin
                            r_force <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                        S_ADDR: r_state <= S_DIG2;
                        S_DIG2: r_state <= S_DIG1;
                        S_DIG1: r_state <= S_DIG0;
                        S_DIG0: begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                        default: r_state <= S_PWRUP;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_value_display.sv
// Directed bench for lcd_value_display: decodes every lcd_e pulse and checks bytes, widths and gaps.
module tb_lcd_value_display;
    localparam int unsigned T_PWRUP = 20;
    localparam int unsigned T_EPW   = 2;
    localparam int unsigned T_CMD   = 4;
    localparam int unsigned T_CLR   = 8;
    localparam int unsigned BOUND   = 3000;

    typedef struct packed {
        logic [8:0]  b;
        logic [31:0] w;
        logic [31:0] gap;
        logic        pv;
        logic [8:0]  prev;
        logic        hold_ok;
    } rec_t;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    lcd_value_display_if bus();

    lcd_value_display #(
        .T_PWRUP (T_PWRUP),
        .T_EPW   (T_EPW),
        .T_CMD   (T_CMD),
        .T_CLR   (T_CLR)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    rec_t        q[$];
    rec_t        cur;
    logic        e_prev  = 1'b0;
    logic        pv      = 1'b0;
    logic [8:0]  last_b  = 9'h000;
    int unsigned gap_cnt = 0;
    int unsigned n_rise  = 0;
    logic [8:0]  exp_q[$];

    // Pulse recorder: captures {rs,db} at the rise, width, hold stability and the preceding low gap
    always @(negedge clk_in) begin
        if (!rst_n) begin
            e_prev  = 1'b0;
            pv      = 1'b0;
            gap_cnt = 0;
        end else begin
            if (bus.lcd_e) begin
                if (!e_prev) begin
                    cur.b       = {bus.lcd_rs, bus.lcd_db};
                    cur.w       = 0;
                    cur.gap     = gap_cnt;
                    cur.pv      = pv;
                    cur.prev    = last_b;
                    cur.hold_ok = 1'b1;
                    n_rise      = n_rise + 1;
                end
                cur.w = cur.w + 1;
                if ({bus.lcd_rs, bus.lcd_db} !== cur.b) cur.hold_ok = 1'b0;
            end else if (e_prev) begin
                if ({bus.lcd_rs, bus.lcd_db} !== cur.b) cur.hold_ok = 1'b0;
                q.push_back(cur);
                pv      = 1'b1;
                last_b  = cur.b;
                gap_cnt = 1;
            end else begin
                gap_cnt = gap_cnt + 1;
            end
            e_prev = bus.lcd_e;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_seq(input string tag);
        rec_t        r;
        int unsigned req;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s pulse%0d present", tag, i), 32'(q.size() > 0), 32'd1);
            if (q.size() == 0) return;
            r = q.pop_front();
            chk($sformatf("%s byte%0d", tag, i), 32'(r.b), 32'(exp_q[i]));
            chk($sformatf("%s width%0d", tag, i), r.w, 32'(T_EPW));
            chk($sformatf("%s hold%0d", tag, i), 32'(r.hold_ok), 32'd1);
            if (r.pv) begin
                req = (r.prev == 9'h001) ? T_CLR : T_CMD;
                chk($sformatf("%s gap%0d>=%0d (got %0d)", tag, i, req, r.gap), 32'(r.gap >= req), 32'd1);
            end
        end
        chk({tag, " extra pulses"}, 32'(q.size()), 32'd0);
    endtask

    task automatic wait_q(input int unsigned n, input string tag);
        int unsigned c = 0;
        while (q.size() < n && c < BOUND) begin
            @(negedge clk_in);
            c++;
        end
        chk({tag, " pulses arrived"}, 32'(q.size() >= n), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input string tag, output int unsigned c);
        c = 0;
        while (bus.busy !== lvl && c < BOUND) begin
            @(negedge clk_in);
            c++;
        end
        chk({tag, " busy level"}, 32'(bus.busy), 32'(lvl));
    endtask

    task automatic wait_rise(input int unsigned n, input string tag);
        int unsigned c = 0;
        while (n_rise < n && c < BOUND) begin
            @(negedge clk_in);
            c++;
        end
        chk({tag, " rise seen"}, 32'(n_rise >= n), 32'd1);
    endtask

    task automatic set_init_exp();
        exp_q = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    endtask

    task automatic run_update(input logic [7:0] v, input string tag);
        int unsigned c;
        bus.value = v;
        wait_q(4, tag);
        wait_busy(1'b0, tag, c);
        check_seq(tag);
    endtask

    initial begin
        int unsigned c;
        int unsigned base;
        logic        e_at_drop;

        bus.value = 8'd0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rst busy", 32'(bus.busy), 32'd1);
        chk("rst lcd_e", 32'(bus.lcd_e), 32'd0);
        chk("rst lcd_rs", 32'(bus.lcd_rs), 32'd0);
        chk("rst lcd_rw", 32'(bus.lcd_rw), 32'd0);
        chk("rst lcd_db", 32'(bus.lcd_db), 32'd0);

        // Power-up: silence for T_PWRUP, then init list and a forced "  0"
        rst_n = 1'b1;
        base  = n_rise;
        repeat (T_PWRUP) @(negedge clk_in);
        chk("pwrup silent", 32'(n_rise - base), 32'd0);
        set_init_exp();
        exp_q.push_back(9'h120); exp_q.push_back(9'h120); exp_q.push_back(9'h130);
        wait_q(11, "init");
        wait_busy(1'b0, "init", c);
        check_seq("init");

        // Idle with an unchanged value keeps the bus quiet
        repeat (10) @(negedge clk_in);
        chk("idle quiet", 32'(q.size()), 32'd0);
        chk("idle busy", 32'(bus.busy), 32'd0);

        exp_q = '{9'h080, 9'h120, 9'h120, 9'h137};
        run_update(8'd7, "v7");
        exp_q = '{9'h080, 9'h132, 9'h135, 9'h135};
        run_update(8'd255, "v255");
        exp_q = '{9'h080, 9'h131, 9'h130, 9'h130};
        run_update(8'd100, "v100");

        // Value change during the DIG2 strobe is deferred to a follow-up update
        base      = n_rise;
        bus.value = 8'd42;
        wait_rise(base + 2, "v42 dig2");
        bus.value = 8'd43;
        wait_q(4, "v42");
        wait_busy(1'b0, "v42", c);
        exp_q = '{9'h080, 9'h120, 9'h134, 9'h132};
        check_seq("v42");
        wait_busy(1'b1, "v43 start", c);
        chk("v43 idle cycles", 32'(c), 32'd1);
        wait_q(4, "v43");
        wait_busy(1'b0, "v43", c);
        exp_q = '{9'h080, 9'h120, 9'h134, 9'h133};
        check_seq("v43");

        // Reset during the DIG1 strobe aborts and restarts from power-up
        base      = n_rise;
        bus.value = 8'd200;
        wait_rise(base + 3, "v200 dig1");
        e_at_drop = bus.lcd_e;
        rst_n     = 1'b0;
        #1;
        chk("abort e high before", 32'(e_at_drop), 32'd1);
        chk("abort lcd_e", 32'(bus.lcd_e), 32'd0);
        chk("abort busy", 32'(bus.busy), 32'd1);
        chk("abort lcd_db", 32'(bus.lcd_db), 32'd0);
        q.delete();
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        base  = n_rise;
        repeat (T_PWRUP) @(negedge clk_in);
        chk("re-pwrup silent", 32'(n_rise - base), 32'd0);
        set_init_exp();
        exp_q.push_back(9'h132); exp_q.push_back(9'h130); exp_q.push_back(9'h130);
        wait_q(11, "reinit");
        wait_busy(1'b0, "reinit", c);
        check_seq("reinit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
